fir_decim_buf: RTL and testbench
================================

Name: fir_decim_buf

Overview:
Downstream consumer of the 8th-order FIR output stage. Sums every DECIM consecutive valid FIR samples into one decimated result, then queues results in a small first-word-fall-through FIFO. The FIFO drains over a valid/ready handshake to the capture/file-dump logic. Flags any result lost to backpressure with a sticky overflow bit.

Parameters:
DIN_W, 10, width of FIR output sample (unsigned)
LOG2_DECIM, 2, log2 of decimation factor; DECIM = 2**LOG2_DECIM
DOUT_W, DIN_W+LOG2_DECIM, result width; full sum, never wraps
FIFO_DEPTH, 8, result FIFO entries, power of 2, >=2

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
in_valid  input  1  Data_in holds a valid FIR sample this cycle
Data_in  input  DIN_W  FIR sample, unsigned
out_ready  input  1  consumer accepts Data_out this cycle
out_valid  output  1  FIFO non-empty; Data_out valid
Data_out  output  DOUT_W  head-of-FIFO decimated sum
fifo_count  output  log2(FIFO_DEPTH)+1  entries currently held
overflow  output  1  sticky: a result was dropped because the FIFO was full
ovf_clr  input  1  synchronous clear of overflow

Behaviour:
- Reset (reset=0, asynchronous): accumulator=0, phase=0, FIFO empty, out_valid=0, Data_out=0, fifo_count=0, overflow=0. Reset mid-accumulation discards the partial sum.
- Accumulate: phase counter 0..DECIM-1 advances only when in_valid=1. Cycles with in_valid=0 hold acc and phase.
- On phase 0, acc <= Data_in. On other phases, acc <= acc + Data_in.
- On a valid sample at phase DECIM-1: result = acc + Data_in is pushed to the FIFO that edge; phase wraps to 0; the next sample starts a fresh sum.
- Latency: result is visible on Data_out with out_valid=1 the cycle after the edge that captured the DECIM-th sample, when the FIFO was empty.
- Data_out is always the head entry. Data_out=0 when empty.
- Pop occurs when out_valid && out_ready. Data_out must not change while out_valid=1 and out_ready=0.
- Push is accepted when the FIFO is not full, or when it is full and a pop occurs on the same edge (count unchanged).
- Push when full with no pop: result dropped, overflow<=1, FIFO contents untouched. Accumulation continues normally.
- Simultaneous push and pop when empty: the pushed value does not bypass. out_valid rises the next cycle.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
- ovf_clr=1 clears overflow. If an overflow drop and ovf_clr occur on the same edge, the set wins (overflow=1).
- No internal arithmetic wraps: max result = DECIM*(2**DIN_W-1), which fits in DOUT_W.

Decomposition:
- Shared package fir_pkg: DIN_W, LOG2_DECIM, DOUT_W, FIFO_DEPTH defaults, and the derived count width constant.
- One sub-module, fir_res_fifo: generic synchronous FWFT FIFO (push/pop/full/empty/count) instantiated with DOUT_W x FIFO_DEPTH.
- Accumulator, phase counter and overflow logic stay in the top level.

Test Plan:
- Reset: hold reset=0 with in_valid=1 and random Data_in -> out_valid=0, Data_out=0, fifo_count=0, overflow=0. Release -> first result only after 4 new valid samples.
- Ramp: in_valid=1, Data_in=1,2,3,4,5,6,7,8, out_ready=1 -> Data_out=10 one cycle after sample 4, then 26 one cycle after sample 8. Each result has out_valid high for exactly 1 cycle.
- Gaps: Data_in 100, idle 3 cycles, 200, idle 1 cycle, 300, 400 -> single result 1000, with no result during the gaps.
- Max value: four samples of 1023 -> Data_out=4092 (12'hFFC), no wrap.
- Backpressure: out_ready=0, 9 groups of 4 samples of value k (k=1..9) -> fifo_count=8, overflow=1, sum 36 dropped. Raise out_ready -> drains 4,8,...,32 in order; ovf_clr pulse -> overflow=0.
- Full with same-cycle pop, plus reset mid-sum: with FIFO full, the 9th push coincides with a pop -> accepted, overflow stays 0. Separately: 2 samples, reset pulse, then 5,5,5,5 -> Data_out=20.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants for the decimating FIR result buffer.
//   DEF_DIN_W      : FIR sample width (unsigned)
//   DEF_LOG2_DECIM : log2 of the decimation factor
//   DEF_DOUT_W     : decimated result width; wide enough that a full sum never wraps
//   DEF_FIFO_DEPTH : result FIFO entries (power of 2, >= 2)
//   DEF_CNT_W      : width of a 0..FIFO_DEPTH occupancy count
package fir_pkg;

  localparam int DEF_DIN_W      = 10;
  localparam int DEF_LOG2_DECIM = 2;
  localparam int DEF_DOUT_W     = DEF_DIN_W + DEF_LOG2_DECIM;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_CNT_W      = $clog2(DEF_FIFO_DEPTH) + 1;

endpackage

// File: rtl/fir_res_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
//   clk, reset : clock, asynchronous active-low reset
//   push/wdata : write request and data; a write into a full FIFO is taken
//                only when a read happens on the same edge
//   pop        : read request; ignored while empty
//   rdata      : head entry, 0 while empty
//   full/empty : occupancy flags
//   count      : entries held, 0..DEPTH
module fir_res_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fir_decim_buf.sv
// Sums every DECIM valid FIR samples into one result and queues results in a
// FWFT FIFO drained over valid/ready.
//   clk, reset        : clock, asynchronous active-low reset
//   in_valid, Data_in : FIR sample stream (unsigned)
//   out_ready         : consumer accepts Data_out
//   out_valid         : FIFO non-empty
//   Data_out          : head-of-FIFO decimated sum (0 when empty)
//   fifo_count        : entries held
//   overflow          : sticky, a result was dropped on a full FIFO
//   ovf_clr           : synchronous clear of overflow (a same-edge drop wins)
module fir_decim_buf
  import fir_pkg::*;
#(
  parameter int DIN_W      = DEF_DIN_W,
  parameter int LOG2_DECIM = DEF_LOG2_DECIM,
  parameter int DOUT_W     = DIN_W + LOG2_DECIM,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [DIN_W-1:0]              Data_in,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [DOUT_W-1:0]             Data_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  logic [LOG2_DECIM-1:0] phase_q, phase_d;
  logic [DOUT_W-1:0]     acc_q, acc_d;
  logic                  ovf_q, ovf_d;
  logic [DOUT_W-1:0]     sum;
  logic                  push, pop, full, empty;

  // Phase 0 starts a fresh sum, so the stale accumulator is ignored there.
  always_comb begin
    sum     = ((phase_q == '0) ? '0 : acc_q) + DOUT_W'(Data_in);
    push    = in_valid && (phase_q == '1);
    pop     = out_valid && out_ready;
    acc_d   = in_valid ? sum : acc_q;
    phase_d = in_valid ? phase_q + LOG2_DECIM'(1) : phase_q;
    ovf_d   = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (push && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  fir_res_fifo #(
    .WIDTH (DOUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (sum),
    .pop   (pop),
    .rdata (Data_out),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign out_valid = !empty;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_fir_decim_buf.sv
module tb_fir_decim_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [9:0]  Data_in;
  logic        out_ready;
  logic        out_valid;
  logic [11:0] Data_out;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        ovf_clr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fir_decim_buf dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .Data_in    (Data_in),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .Data_out   (Data_out),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are observed there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [9:0] v);
    in_valid = 1'b1;
    Data_in  = v;
    tick();
    in_valid = 1'b0;
  endtask

  int ramp_exp_valid [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    reset = 1'b0; in_valid = 1'b1; Data_in = 10'd0;
    out_ready = 1'b1; ovf_clr = 1'b0;

    // Reset held with active input
    for (int i = 0; i < 4; i++) begin
      Data_in = 10'($urandom_range(0, 1023));
      tick();
    end
    chk("rst_valid", out_valid, 0);
    chk("rst_dout", Data_out, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b1;

    // Ramp 1..8; first result only after four new samples
    for (int i = 0; i < 8; i++) begin
      sample(10'(i + 1));
      chk($sformatf("ramp_valid%0d", i + 1), out_valid, ramp_exp_valid[i]);
      if (i == 3) chk("ramp_r0", Data_out, 10);
      if (i == 7) chk("ramp_r1", Data_out, 26);
    end
    tick();
    chk("ramp_drained", out_valid, 0);

    // Gaps between samples hold the partial sum
    sample(10'd100);
    for (int i = 0; i < 3; i++) tick();
    chk("gap_idle0", out_valid, 0);
    sample(10'd200);
    tick();
    chk("gap_idle1", out_valid, 0);
    sample(10'd300);
    chk("gap_partial", out_valid, 0);
    sample(10'd400);
    chk("gap_valid", out_valid, 1);
    chk("gap_sum", Data_out, 1000);
    tick();

    // Maximum sum
    for (int i = 0; i < 4; i++) sample(10'd1023);
    chk("max_sum", Data_out, 12'hFFC);
    tick();
    chk("max_drained", fifo_count, 0);

    // Backpressure and overflow drop
    out_ready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      for (int j = 0; j < 4; j++) sample(10'(k));
      if (k == 8) chk("bp_full_noovf", overflow, 0);
    end
    chk("bp_count", fifo_count, 8);
    chk("bp_ovf", overflow, 1);
    chk("bp_head", Data_out, 4);
    tick();
    chk("bp_hold", Data_out, 4);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("bp_drain%0d", i), Data_out, 4 * i);
      tick();
    end
    chk("bp_empty", out_valid, 0);
    chk("bp_empty_dout", Data_out, 0);
    chk("bp_ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", overflow, 0);

    // Full FIFO with a push coinciding with a pop
    out_ready = 1'b0;
    for (int k = 1; k <= 8; k++)
      for (int j = 0; j < 4; j++) sample(10'(k));
    chk("fp_count_full", fifo_count, 8);
    for (int j = 0; j < 3; j++) sample(10'd9);
    out_ready = 1'b1;
    sample(10'd9);
    chk("fp_count", fifo_count, 8);
    chk("fp_ovf", overflow, 0);
    for (int i = 2; i <= 9; i++) begin
      chk($sformatf("fp_drain%0d", i), Data_out, 4 * i);
      tick();
    end
    chk("fp_empty", fifo_count, 0);

    // Reset mid-sum discards the partial sum
    sample(10'd7);
    sample(10'd7);
    reset = 1'b0;
    #1;
    chk("mid_rst_count", fifo_count, 0);
    tick();
    reset = 1'b1;
    for (int j = 0; j < 3; j++) sample(10'd5);
    chk("mid_rst_partial", out_valid, 0);
    sample(10'd5);
    chk("mid_rst_valid", out_valid, 1);
    chk("mid_rst_sum", Data_out, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
